// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: ISA opcodes, control-word layout and datapath width.
// Used by the decode, execute and memory-access stages.
package mem_stage_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned CTRL_W         = 5;
    localparam int unsigned CTRL_VALID_BIT = 4;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_SUB    = 4'd1,
        OP_ADD    = 4'd2,
        OP_ADDI   = 4'd3,
        OP_SHLLI  = 4'd4,
        OP_SHRLI  = 4'd5,
        OP_JUMP   = 4'd6,
        OP_JUMPZ  = 4'd7,
        OP_JUMPNZ = 4'd8,
        OP_JUMPEQ = 4'd9,
        OP_JUMPNE = 4'd10,
        OP_CMP    = 4'd11,
        OP_LOAD   = 4'd12,
        OP_LOADI  = 4'd13,
        OP_STORE  = 4'd14,
        OP_MOV    = 4'd15
    } opcode_t;

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_port_ctrl.sv
// Data-memory port sequencer: IDLE/RD_WAIT/WR_WAIT FSM plus the request latches
// that hold address, write data and load destination until mem_ready.
module mem_port_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEST_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_rd,
    input  logic              start_wr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic              mem_ready,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rd_done,
    output logic              wr_done,
    output logic [DEST_W-1:0] rd_dest
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: begin
                if (start_rd) begin
                    state_nxt = RD_WAIT;
                end else if (start_wr) begin
                    state_nxt = WR_WAIT;
                end
            end
            RD_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_WAIT: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign launch = (state == IDLE) && (start_rd || start_wr);

    // Latches load only on launch, so the request stays frozen while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_dest   <= '0;
        end else if (launch) begin
            mem_addr <= addr_in;
            if (start_wr) begin
                mem_wdata <= wdata_in;
            end
            if (start_rd) begin
                rd_dest <= dest_in;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues LOAD/STORE on the data-memory port,
// stalls upstream while waiting, and registers the write-back bundle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEST_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ex_control,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DEST_W-1:0] ex_dest,
    input  logic              ex_we,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [DEST_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data
);

    opcode_t           op;
    logic              accept;
    logic              start_rd;
    logic              start_wr;
    logic              rd_done;
    logic              wr_done;
    logic [DEST_W-1:0] rd_dest;

    assign op       = opcode_t'(ex_control[3:0]);
    assign accept   = ex_control[CTRL_VALID_BIT] && !stall;
    assign start_rd = accept && (op == OP_LOAD);
    assign start_wr = accept && (op == OP_STORE);

    mem_port_ctrl #(
        .ADDR_W (ADDR_W),
        .DEST_W (DEST_W)
    ) u_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_rd  (start_rd),
        .start_wr  (start_wr),
        .addr_in   (ex_result[ADDR_W-1:0]),
        .wdata_in  (ex_store_data),
        .dest_in   (ex_dest),
        .mem_ready (mem_ready),
        .busy      (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rd_done   (rd_done),
        .wr_done   (wr_done),
        .rd_dest   (rd_dest)
    );

    // Completion and accept are mutually exclusive: accept needs IDLE, completion needs a wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            if (rd_done) begin
                wb_valid <= 1'b1;
                wb_we    <= 1'b1;
                wb_dest  <= rd_dest;
                wb_data  <= mem_rdata;
            end else if (wr_done) begin
                wb_valid <= 1'b1;
            end else if (accept && !is_mem_op(op)) begin
                wb_valid <= 1'b1;
                wb_we    <= ex_we;
                wb_dest  <= ex_dest;
                wb_data  <= ex_result;
            end
        end
    end

    assign fwd_valid = wb_valid && wb_we;
    assign fwd_dest  = wb_dest;
    assign fwd_data  = wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases plus random instruction stream
// against a flat-memory reference model.
`timescale 1ns/1ps
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEST_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [4:0]        ex_control = 5'd0;
    logic [15:0]       ex_result = 16'd0;
    logic [15:0]       ex_store_data = 16'd0;
    logic [DEST_W-1:0] ex_dest = 6'd0;
    logic              ex_we = 1'b0;
    logic              stall, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata = 16'd0;
    logic              mem_ready = 1'b0;
    logic              wb_valid, wb_we, fwd_valid;
    logic [DEST_W-1:0] wb_dest, fwd_dest;
    logic [15:0]       wb_data, fwd_data;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(ADDR_W), .DEST_W(DEST_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_control(ex_control), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_we(ex_we), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_dest(wb_dest), .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data)
    );

    typedef struct {
        logic              we;
        logic [DEST_W-1:0] dest;
        logic [15:0]       data;
    } wb_t;

    wb_t         exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    int          fixed_lat = -1;
    bit          spur_en = 1'b0;
    bit          spur_force = 1'b0;
    int          lat_left = 0;
    bit          waiting = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory device: fixed or random wait states, array updated through the port.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            waiting   = 1'b0;
        end else if (mem_req) begin
            if (!waiting) begin
                waiting  = 1'b1;
                lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (lat_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
                waiting = 1'b0;
            end else begin
                lat_left--;
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end else begin
            waiting   = 1'b0;
            mem_rdata = 16'($urandom);
            mem_ready = spur_force || (spur_en && ($urandom_range(0, 3) == 0));
        end
    end

    // Monitor: every write-back must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wb_t e;
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb_queue_depth", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("wb_we", 32'(wb_we), 32'(e.we));
                chk("fwd_valid", 32'(fwd_valid), 32'(e.we));
                if (e.we) begin
                    chk("wb_dest", 32'(wb_dest), 32'(e.dest));
                    chk("wb_data", 32'(wb_data), 32'(e.data));
                    chk("fwd_dest", 32'(fwd_dest), 32'(e.dest));
                    chk("fwd_data", 32'(fwd_data), 32'(e.data));
                end
            end
        end
    end

    // Present an instruction at a negedge, hold it while stalled, record its expected write-back.
    task automatic issue(input logic [3:0] op, input logic [15:0] res, input logic [15:0] sdata,
                         input logic [DEST_W-1:0] dest, input logic we);
        int  n = 0;
        wb_t e;
        ex_control    = {1'b1, op};
        ex_result     = res;
        ex_store_data = sdata;
        ex_dest       = dest;
        ex_we         = we;
        while (stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            chk("accept_timeout_stall", 32'(stall), 0);
        end else begin
            if (op == 4'd12) begin
                e = '{1'b1, dest, ref_mem[res]};
            end else if (op == 4'd14) begin
                e = '{1'b0, dest, 16'd0};
                ref_mem[res] = sdata;
            end else begin
                e = '{we, dest, res};
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        ex_control = {1'b0, op};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int nwb;
        logic [3:0] op;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i * 7 + 3);
            ref_mem[i] = mem[i];
        end

        // Reset values
        #12;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op
        issue(4'd2, 16'h1234, 16'h0000, 6'd5, 1'b1);
        chk("add_fwd_valid", 32'(fwd_valid), 1);

        // LOAD, ready in the third request cycle
        fixed_lat = 2;
        mem[16'h0040]     = 16'hBEEF;
        ref_mem[16'h0040] = 16'hBEEF;
        issue(4'd12, 16'h0040, 16'h0000, 6'd9, 1'b0);
        n = 0;
        while (stall && n < 20) begin
            chk("ld_mem_addr", 32'(mem_addr), 32'h40);
            chk("ld_mem_req", 32'(mem_req), 1);
            n++;
            @(negedge clk);
        end
        chk("ld_stall_cycles", n, 3);

        // STORE, zero wait
        fixed_lat = 0;
        issue(4'd14, 16'h0010, 16'hA5A5, 6'd3, 1'b1);
        chk("st_mem_req", 32'(mem_req), 1);
        chk("st_mem_we", 32'(mem_we), 1);
        chk("st_mem_wdata", 32'(mem_wdata), 32'hA5A5);
        chk("st_mem_addr", 32'(mem_addr), 32'h10);
        @(negedge clk);
        chk("st_stall_after", 32'(stall), 0);
        chk("st_req_after", 32'(mem_req), 0);
        chk("st_mem_content", 32'(mem[16'h0010]), 32'hA5A5);

        // LOAD followed by an ADD held during the stall
        fixed_lat = 1;
        issue(4'd12, 16'h0020, 16'h0000, 6'd7, 1'b1);
        issue(4'd2, 16'h4321, 16'h0000, 6'd8, 1'b1);
        chk("b2b_add_wb_valid", 32'(wb_valid), 1);
        chk("b2b_add_dest", 32'(wb_dest), 32'd8);
        @(negedge clk);
        chk("b2b_no_dup", 32'(wb_valid), 0);

        // Spurious mem_ready while idle and an invalid ADD
        spur_force = 1'b1;
        ex_control = {1'b0, 4'd2};
        ex_result  = 16'hFFFF;
        repeat (4) begin
            @(negedge clk);
            chk("spur_wb_valid", 32'(wb_valid), 0);
            chk("spur_stall", 32'(stall), 0);
            chk("spur_mem_req", 32'(mem_req), 0);
        end
        spur_force = 1'b0;

        // Random instruction stream
        fixed_lat = -1;
        spur_en   = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            op = 4'($urandom_range(0, 15));
            issue(op, 16'($urandom), 16'($urandom), 6'($urandom), 1'($urandom));
        end
        repeat (8) @(negedge clk);
        chk("random_queue_drained", 32'(exp_q.size()), 0);

        // Reset while a LOAD waits in RD_WAIT
        spur_en    = 1'b0;
        fixed_lat  = 6;
        ex_control = {1'b1, 4'd12};
        ex_result  = 16'h0077;
        ex_dest    = 6'd2;
        @(negedge clk);
        ex_control = 5'd0;
        chk("rdw_stall", 32'(stall), 1);
        chk("rdw_mem_req", 32'(mem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rdw_rst_mem_req", 32'(mem_req), 0);
        chk("rdw_rst_stall", 32'(stall), 0);
        chk("rdw_rst_wb_valid", 32'(wb_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nwb = 0;
        repeat (8) begin
            @(negedge clk);
            if (wb_valid) nwb++;
        end
        chk("rdw_no_wb_after_release", nwb, 0);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
